// File: rtl/decode_pkg.sv
// Shared opcodes, format codes and the decoded-beat record for the decode stage.
// pc and imm are stored at the widest supported XLEN and sliced by each user.
package decode_pkg;

   localparam int MAX_XLEN = 64;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_INV = 3'd7;

   typedef struct packed {
      logic [MAX_XLEN-1:0] pc;
      logic [4:0]          a1;
      logic [4:0]          a2;
      logic [4:0]          a3;
      logic [6:0]          op;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [MAX_XLEN-1:0] imm;
      logic [2:0]          fmt;
      logic                illegal;
   } beat_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational format classification and sign-extended immediate builder.
// Unknown opcodes and compressed-looking encodings decode as invalid with imm = 0.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);

   // Signed size casts replicate the top immediate bit up to XLEN.
   always_comb begin
      imm     = '0;
      fmt     = FMT_INV;
      illegal = 1'b0;
      if (instr[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (instr[6:0])
            OP_R: fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
               fmt = FMT_I;
               imm = XLEN'($signed(instr[31:20]));
            end
            OP_STORE: begin
               fmt = FMT_S;
               imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OP_BRANCH: begin
               fmt = FMT_B;
               imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
               fmt = FMT_U;
               imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OP_JAL: begin
               fmt = FMT_J;
               imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage between fetch and execute with an optional skid entry
// so that in_ready depends only on registered occupancy, never on out_ready.
module instr_decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit USE_SKID = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_a1,
   output logic [4:0]      out_a2,
   output logic [4:0]      out_a3,
   output logic [6:0]      out_op,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;
   beat_t           in_beat;
   beat_t           out_q;
   beat_t           skid_q;
   logic            out_valid_q;
   logic            skid_valid;
   logic            in_xfer;
   logic            stalled;
   logic            unused_hi;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr   (in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   always_comb begin
      in_beat         = '0;
      in_beat.pc      = MAX_XLEN'(in_pc);
      in_beat.a1      = in_instr[19:15];
      in_beat.a2      = in_instr[24:20];
      in_beat.a3      = in_instr[11:7];
      in_beat.op      = in_instr[6:0];
      in_beat.funct3  = in_instr[14:12];
      in_beat.funct7  = in_instr[31:25];
      in_beat.imm     = MAX_XLEN'(dec_imm);
      in_beat.fmt     = dec_fmt;
      in_beat.illegal = dec_illegal;
   end

   assign in_ready = USE_SKID ? ~skid_valid : (out_ready | ~out_valid_q);
   assign in_xfer  = in_valid & in_ready & ~flush;
   assign stalled  = out_valid_q & ~out_ready;

   // Flush wins; a stalled output parks the new beat in skid, otherwise skid drains first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (stalled) begin
         if (USE_SKID && in_xfer) begin
            skid_q     <= in_beat;
            skid_valid <= 1'b1;
         end
      end else if (skid_valid) begin
         out_q       <= skid_q;
         out_valid_q <= 1'b1;
         skid_valid  <= 1'b0;
      end else if (in_xfer) begin
         out_q       <= in_beat;
         out_valid_q <= 1'b1;
      end else begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_pc      = out_q.pc[XLEN-1:0];
   assign out_a1      = out_q.a1;
   assign out_a2      = out_q.a2;
   assign out_a3      = out_q.a3;
   assign out_op      = out_q.op;
   assign out_funct3  = out_q.funct3;
   assign out_funct7  = out_q.funct7;
   assign out_imm     = out_q.imm[XLEN-1:0];
   assign out_fmt     = out_q.fmt;
   assign out_illegal = out_q.illegal;
   assign unused_hi   = ^{out_q.pc, out_q.imm};

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
Registered instruction decode stage for the pipelined RISC-V core. It splits a 32-bit instruction into its register, opcode and funct fields, builds the format-correct sign-extended immediate at XLEN width, and flags illegal encodings. It sits between fetch and execute and connects to both through valid/ready handshakes. It has a 2-entry skid buffer, so a downstream stall does not create a combinational ready path back to fetch, and it supports a pipeline flush.

Parameters:
XLEN, 32, datapath width of pc and imm (32 or 64)
USE_SKID, 1, 1 = 2-entry skid buffer; 0 = single output register with in_ready = out_ready | ~out_valid

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all held entries and the current input beat
in_valid  in  1  fetch beat valid
in_ready  out  1  stage can accept a beat
in_instr  in  32  raw instruction
in_pc  in  XLEN  pc of in_instr
out_valid  out  1  decoded beat valid
out_ready  in  1  execute accepts the beat
out_pc  out  XLEN  registered pc
out_a1  out  5  rs1 = instr[19:15]
out_a2  out  5  rs2 = instr[24:20]
out_a3  out  5  rd = instr[11:7]
out_op  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 invalid
out_illegal  out  1  unsupported opcode, or instr[1:0] != 2'b11

Behaviour:
- Reset (rst_n low, asynchronous):
  - all out_* = 0, out_valid = 0, skid entry empty.
  - in_ready = 1, because it is derived only from skid occupancy.
- Decode is combinational on in_instr and is captured with the beat. Latency is 1 cycle: an accepted beat appears on out_* on the next edge.
- Handshake rules:
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - out_* hold stable while out_valid & ~out_ready.
- USE_SKID=1:
  - in_ready = ~skid_valid, a registered signal.
  - If a beat is accepted while the output register is full and not draining, it goes to the skid register.
  - When the output drains, the skid entry moves to the output register. A simultaneous new input is not possible, since in_ready=0 when skid_valid=1.
  - Order is strictly FIFO.
- Format selection by opcode:
  - 0110011 → R, imm = 0.
  - 0010011, 0000011, 1100111, 1110011 → I, imm = sext(instr[31:20]).
  - 0100011 → S, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 → B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111 → U, imm = sext({instr[31:12], 12'b0}).
  - 1101111 → J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Anything else, or instr[1:0] != 11 → fmt = 7, illegal = 1, imm = 0.
  - Field outputs are always passed through regardless of format.
- Sign extension always goes to XLEN. For U at XLEN=64, bits 63:32 replicate instr[31].
- Flush:
  - On the next edge, out_valid = 0 and the skid entry is emptied; data registers keep their value.
  - The input beat in the flush cycle is dropped even if in_valid & in_ready.
  - in_ready = 1 in the cycle after the flush.
- Flush has priority over every simultaneous transfer.
- Reset mid-stream drops all held beats immediately.
- Back-to-back throughput is 1 beat/cycle when out_ready is held high.

Decomposition:
- decode_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL);
  - the fmt encoding constants FMT_R … FMT_INV;
  - the decoded-beat struct {pc, a1, a2, a3, op, funct3, funct7, imm, fmt, illegal}.
- Sub-module imm_gen is combinational: in instr[31:0], out imm[XLEN-1:0], fmt, illegal. It is instantiated once, before the buffer.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), pc 0x100, out_ready=1 → next cycle: out_valid=1, a3=1, a1=2, fmt=1, imm=0xFFFFFFFF, out_pc=0x100, illegal=0.
- sw x5,8(x6) (0x00532423), then beq x0,x0,-4 (0xFE000EE3) back to back → sw: fmt=2, a1=6, a2=5, imm=8; beq: fmt=3, imm=0xFFFFFFFC on consecutive cycles.
- jal x1,2048 (0x001000EF) → fmt=5, imm=0x00000800. lui x3,0x12345 (0x123451B7) → fmt=4, imm=0x12345000. At XLEN=64, lui 0x800001B7 → imm=0xFFFFFFFF80000000.
- Illegal 0x00000000 → illegal=1, fmt=7, imm=0, out_valid=1.
- Backpressure:
  - Stimulus: hold out_ready=0 and drive 3 beats A,B,C.
  - Required: A in the output register, B in skid, in_ready=0 from the cycle after B is accepted, C not accepted.
  - Release out_ready → A, B, C emerge in order with no loss or duplication.
- Flush with output and skid full plus in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed input beat never appears.
- Assert rst_n=0 mid-stream → out_valid drops asynchronously with no clock edge.
